// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the VGA pipeline: the 4-bit key codes consumed by
//   the menu/text drawing stage, the PS/2 set-2 scan-code bytes that produce
//   them, the keyboard decoder state type and the scan-code lookup function.
//   No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    // Key codes presented to the menu/text stage
    localparam logic [3:0] key_none = 4'h0;
    localparam logic [3:0] key_1    = 4'h1;
    localparam logic [3:0] key_2    = 4'h2;
    localparam logic [3:0] key_3    = 4'h3;
    localparam logic [3:0] key_4    = 4'h4;
    localparam logic [3:0] key_up   = 4'h5;
    localparam logic [3:0] key_down = 4'h6;
    localparam logic [3:0] key_esc  = 4'hF;

    // PS/2 set-2 scan-code bytes
    localparam logic [7:0] PS2_MAKE_1    = 8'h16;
    localparam logic [7:0] PS2_MAKE_2    = 8'h1E;
    localparam logic [7:0] PS2_MAKE_3    = 8'h26;
    localparam logic [7:0] PS2_MAKE_4    = 8'h25;
    localparam logic [7:0] PS2_MAKE_ESC  = 8'h76;
    localparam logic [7:0] PS2_MAKE_UP   = 8'h75;
    localparam logic [7:0] PS2_MAKE_DOWN = 8'h72;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;

    // Scan-code sequence decoder states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

    // Translate a scan code plus its extended flag into a key code.
    // Arrow keys only exist as extended codes and the plain keys only as
    // non-extended codes, so any mismatch yields key_none (ignored).
    function automatic logic [3:0] map_scan_code(input logic [7:0] code,
                                                 input logic       ext);
        logic [3:0] k;
        k = key_none;
        if (ext) begin
            case (code)
                PS2_MAKE_UP:   k = key_up;
                PS2_MAKE_DOWN: k = key_down;
                default:       k = key_none;
            endcase
        end else begin
            case (code)
                PS2_MAKE_1:   k = key_1;
                PS2_MAKE_2:   k = key_2;
                PS2_MAKE_3:   k = key_3;
                PS2_MAKE_4:   k = key_4;
                PS2_MAKE_ESC: k = key_esc;
                default:      k = key_none;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
//   PS/2 serial receiver. Synchronises the raw PS/2 clock and data pins into
//   the clk domain, samples one bit per falling PS/2 clock edge and assembles
//   11-bit frames (start, 8 data LSB first, odd parity, stop). A partially
//   received frame is abandoned silently when the PS/2 clock stays quiet for
//   TIMEOUT_CYCLES clk cycles.
//
//   Ports
//     clk       in   system clock
//     rst       in   synchronous active-high reset
//     ps2_clk   in   raw PS/2 clock pin (asynchronous)
//     ps2_data  in   raw PS/2 data pin (asynchronous)
//     rx_byte   out  received data byte, valid while rx_valid is high
//     rx_valid  out  one-cycle pulse for a correctly framed byte
//     rx_err    out  one-cycle pulse for a parity, start or stop error
// ---------------------------------------------------------------------------
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic          ps2_data_s1_q, ps2_data_s2_q, ps2_data_s3_q;
    logic          fall_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    shift_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          rx_err_q;
    logic          frame_ok_d;

    // The stop bit is the live data sample when the 11th edge is processed;
    // the first ten bits sit in shift_q with the start bit at position 0.
    // Odd parity means data plus parity bit XOR to one.
    always_comb begin
        frame_ok_d = ~shift_q[0] & (^shift_q[9:1]) & ps2_data_s3_q;
    end

    // Synchronisers, registered falling-edge detect, bit assembly and the
    // inactivity timeout. Synchronisers reset to the idle-high line level so
    // leaving reset never looks like a falling edge. A falling edge always
    // takes priority over the timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_s1_q  <= 1'b1;
            ps2_clk_s2_q  <= 1'b1;
            ps2_clk_s3_q  <= 1'b1;
            ps2_data_s1_q <= 1'b1;
            ps2_data_s2_q <= 1'b1;
            ps2_data_s3_q <= 1'b1;
            fall_q        <= 1'b0;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 10'd0;
            tmo_cnt_q     <= '0;
            rx_byte_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_err_q      <= 1'b0;
        end else begin
            ps2_clk_s1_q  <= ps2_clk;
            ps2_clk_s2_q  <= ps2_clk_s1_q;
            ps2_clk_s3_q  <= ps2_clk_s2_q;
            ps2_data_s1_q <= ps2_data;
            ps2_data_s2_q <= ps2_data_s1_q;
            ps2_data_s3_q <= ps2_data_s2_q;
            fall_q        <= ps2_clk_s3_q & ~ps2_clk_s2_q;
            rx_valid_q    <= 1'b0;
            rx_err_q      <= 1'b0;

            if (fall_q) begin
                tmo_cnt_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q  <= 4'd0;
                    rx_byte_q  <= shift_q[8:1];
                    rx_valid_q <= frame_ok_d;
                    rx_err_q   <= ~frame_ok_d;
                end else begin
                    shift_q   <= {ps2_data_s3_q, shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_cnt_q <= '0;
                    bit_cnt_q <= 4'd0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
            end
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   Turns PS/2 set-2 make/break/extended scan-code sequences into the 4-bit
//   key code used by the menu/text drawing stage. key holds the currently
//   pressed recognised key, or key_none when nothing is held.
//
//   Ports
//     clk        in   system clock (VGA pipeline domain)
//     rst        in   synchronous active-high reset
//     ps2_clk    in   raw PS/2 clock pin (asynchronous)
//     ps2_data   in   raw PS/2 data pin (asynchronous)
//     key        out  decoded key code, registered
//     key_valid  out  one-cycle pulse whenever key changes value
//     frame_err  out  one-cycle pulse on a badly framed PS/2 byte
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import vga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    dec_state_t state_q;
    logic [3:0] key_q;
    logic       key_valid_q;
    logic       frame_err_q;
    logic [3:0] mapped_key_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    // The extended flag is implied by the state the byte arrives in.
    always_comb begin
        mapped_key_d = map_scan_code(rx_byte,
                                     (state_q == ST_EXT) || (state_q == ST_EXT_BRK));
    end

    // Prefix-tracking FSM and key register. A make only pulses key_valid when
    // it changes key, so typematic repeats are silent; a break only releases
    // the key that is currently held. A framing error discards any pending
    // prefix so the next byte is interpreted from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= key_none;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (rx_err) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
            end else if (rx_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == PS2_BRK) begin
                            state_q <= ST_BRK;
                        end else if (rx_byte == PS2_EXT) begin
                            state_q <= ST_EXT;
                        end else if (mapped_key_d != key_none && mapped_key_d != key_q) begin
                            key_q       <= mapped_key_d;
                            key_valid_q <= 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (rx_byte == PS2_BRK) begin
                            state_q <= ST_EXT_BRK;
                        end else begin
                            state_q <= ST_IDLE;
                            if (mapped_key_d != key_none && mapped_key_d != key_q) begin
                                key_q       <= mapped_key_d;
                                key_valid_q <= 1'b1;
                            end
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        state_q <= ST_IDLE;
                        if (mapped_key_d != key_none && mapped_key_d == key_q) begin
                            key_q       <= key_none;
                            key_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//   Drives PS/2 frames into ps2_key_decoder (40 clk per PS/2 bit, data
//   changing mid-high phase) and checks key_valid / frame_err events against
//   a queue of expected events filled by the stimulus process.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key;
    logic       key_valid;
    logic       frame_err;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic       isErr;
        logic [3:0] code;
    } evt_t;

    evt_t expQ[$];
    evt_t gotEvt;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nBits bits of a frame for code, optionally corrupting
    // the parity or stop bit, then leaves the line idle for 60 clk.
    task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                                 input bit badStop, input int nBits);
        logic [10:0] frame;
        frame = {~badStop, (~^code) ^ badParity, code, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            ps2_data = frame[i];
            waitClocks(10);
            ps2_clk = 1'b0;
            waitClocks(20);
            ps2_clk = 1'b1;
            waitClocks(10);
        end
        ps2_data = 1'b1;
        waitClocks(60);
    endtask

    task automatic sendByte(input logic [7:0] code);
        applyStimulus(code, 1'b0, 1'b0, 11);
    endtask

    task automatic expectKey(input logic [3:0] k);
        expQ.push_back('{isErr: 1'b0, code: k});
    endtask

    task automatic expectErr();
        expQ.push_back('{isErr: 1'b1, code: 4'h0});
    endtask

    // Monitor: every DUT event pops one expected event; an event with
    // nothing expected is itself a failure.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpectedKeyValid: got key %0h, expected no event", key);
            end else begin
                gotEvt = expQ.pop_front();
                checkOutput("keyEvent", {3'b000, 1'b0, key}, {3'b000, gotEvt.isErr, gotEvt.code});
            end
        end
        if (!rst && frame_err) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpectedFrameErr: got frame_err 1, expected no event");
            end else begin
                gotEvt = expQ.pop_front();
                checkOutput("errEvent", {3'b000, frame_err, 4'h0}, {3'b000, gotEvt.isErr, gotEvt.code});
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no finish, expected finish within 60000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        waitClocks(5);
        rst = 1'b0;
        waitClocks(2);
        checkOutput("resetKey", {4'h0, key}, 8'h00);
        checkOutput("resetKeyValid", {7'h0, key_valid}, 8'h00);
        checkOutput("resetFrameErr", {7'h0, frame_err}, 8'h00);

        // Plain make and break
        expectKey(4'h2); sendByte(8'h1E);
        checkOutput("make1E", {4'h0, key}, 8'h02);
        expectKey(4'h0); sendByte(8'hF0); sendByte(8'h1E);
        checkOutput("break1E", {4'h0, key}, 8'h00);

        // Typematic repeats give a single pulse
        expectKey(4'h2); sendByte(8'h1E); sendByte(8'h1E); sendByte(8'h1E);
        checkOutput("typematic", {4'h0, key}, 8'h02);
        expectKey(4'h0); sendByte(8'hF0); sendByte(8'h1E);

        // Extended make/break, extended unmapped code
        expectKey(4'h5); sendByte(8'hE0); sendByte(8'h75);
        checkOutput("extMakeUp", {4'h0, key}, 8'h05);
        expectKey(4'h0); sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        checkOutput("extBreakUp", {4'h0, key}, 8'h00);
        sendByte(8'hE0); sendByte(8'h76);
        checkOutput("extUnmapped", {4'h0, key}, 8'h00);

        // Bad parity, then recovery
        expectErr(); applyStimulus(8'h26, 1'b1, 1'b0, 11);
        checkOutput("badParityKey", {4'h0, key}, 8'h00);
        expectKey(4'hF); sendByte(8'h76);
        checkOutput("makeEsc", {4'h0, key}, 8'h0F);

        // Partial frame abandoned by timeout
        applyStimulus(8'h25, 1'b0, 1'b0, 5);
        waitClocks(1200);
        expectKey(4'h4); sendByte(8'h25);
        checkOutput("afterTimeout", {4'h0, key}, 8'h04);

        // Replacement by new make; break of a non-held key ignored
        expectKey(4'h1); sendByte(8'h16);
        expectKey(4'h4); sendByte(8'h25);
        sendByte(8'hF0); sendByte(8'h16);
        checkOutput("breakOtherKey", {4'h0, key}, 8'h04);

        // Reset in the middle of a frame
        applyStimulus(8'h1E, 1'b0, 1'b0, 4);
        rst = 1'b1;
        waitClocks(3);
        rst = 1'b0;
        waitClocks(2);
        checkOutput("midFrameReset", {4'h0, key}, 8'h00);
        expectKey(4'h2); sendByte(8'h1E);
        checkOutput("afterReset", {4'h0, key}, 8'h02);

        // Bad stop bit drops a pending extended prefix
        sendByte(8'hE0);
        expectErr(); applyStimulus(8'h1E, 1'b0, 1'b1, 11);
        sendByte(8'h75);
        checkOutput("errClearsExt", {4'h0, key}, 8'h02);

        for (int i = 0; i < 200 && expQ.size() != 0; i++) waitClocks(1);
        checkOutput("queueDrained", 8'(expQ.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
